// File: rtl/dcfifo_arb_pkg.sv
// Shared types and helpers for the dcfifo write-side arbiter and its
// round-robin picker.
package dcfifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcfifo_rr_picker.sv
// Combinational round-robin picker: returns the first set request bit at
// or after ptr+1, wrapping past N-1 back to 0. Intended for reuse by the
// read-side schedulers as well.
module dcfifo_rr_picker
  import dcfifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                req,
  input  logic [clog2_min1(N)-1:0]    ptr,
  output logic                        found,
  output logic [clog2_min1(N)-1:0]    winner
);

  localparam int IDX_W = clog2_min1(N);

  // Lowest set bit overall is the wrap-around fallback; lowest set bit
  // strictly above ptr overrides it (descending scan keeps the lowest).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        found  = 1'b1;
        winner = IDX_W'(j);
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(ptr))) begin
        winner = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/dcfifo_wr_arbiter.sv
// Round-robin arbiter sharing the single write port of a dcfifo among
// REQUESTERS packet sources. A grant is locked for a whole packet and
// packets are cut at MAX_PKT beats with a one-cycle pkt_err pulse.
// Optional macro DCFIFO_WR_ARB_ADMIT_EN: only start a packet when the
// FIFO has room for MAX_PKT words, so a started packet never stalls.
module dcfifo_wr_arbiter
  import dcfifo_arb_pkg::*;
#(
  parameter int REQUESTERS    = 4,
  parameter int WIDTH         = 8,
  parameter int MAX_PKT       = 16,
  parameter int FIFO_NUMWORDS = 256,
  parameter int FIFO_WIDTHU   = 8
) (
  input  logic                              clk,
  input  logic                              areset_n,
  input  logic [REQUESTERS-1:0]             req_valid,
  input  logic [REQUESTERS-1:0]             req_last,
  input  logic [REQUESTERS*WIDTH-1:0]       req_data,
  output logic [REQUESTERS-1:0]             req_ready,
  output logic                              fifo_wrreq,
  output logic [WIDTH-1:0]                  fifo_data,
  input  logic                              fifo_wrfull,
  input  logic [FIFO_WIDTHU-1:0]            fifo_wrusedw,
  output logic                              grant_active,
  output logic [clog2_min1(REQUESTERS)-1:0] grant_idx,
  output logic                              pkt_err
);

  localparam int IDX_W  = clog2_min1(REQUESTERS);
  localparam int CNT_W  = clog2_min1(MAX_PKT + 1);
  localparam int FREE_W = FIFO_WIDTHU + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_PKT - 1);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(REQUESTERS - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             pkt_err_q, pkt_err_d;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic             admit;
  logic             at_max;
  logic             end_pkt;
  logic [FREE_W-1:0] free_words;
  logic             room_ok;

  dcfifo_rr_picker #(
    .N (REQUESTERS)
  ) u_picker (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .found  (found),
    .winner (winner)
  );

  // wrusedw wraps to 0 when the FIFO is completely full, so wrfull forces
  // the free count to zero.
  assign free_words = fifo_wrfull ? '0
                    : FREE_W'(FIFO_NUMWORDS) - {1'b0, fifo_wrusedw};
  assign room_ok    = (free_words >= FREE_W'(MAX_PKT));

`ifdef DCFIFO_WR_ARB_ADMIT_EN
  assign admit = room_ok;
`else
  logic room_unused;
  assign room_unused = room_ok;
  assign admit       = 1'b1;
`endif

  assign grant_active = (state_q == LOCK);
  assign grant_idx    = grant_idx_q;
  assign pkt_err      = pkt_err_q;

  // Only the locked source sees ready, and only while the FIFO has space.
  always_comb begin
    req_ready = '0;
    if (grant_active && !fifo_wrfull) begin
      req_ready[grant_idx_q] = 1'b1;
    end
  end

  assign fifo_wrreq = req_valid[grant_idx_q] & req_ready[grant_idx_q];
  assign fifo_data  = grant_active ? req_data[int'(grant_idx_q)*WIDTH +: WIDTH]
                                   : '0;

  assign at_max  = (beat_cnt_q == LAST_BEAT);
  assign end_pkt = fifo_wrreq & (req_last[grant_idx_q] | at_max);

  // Next-state logic: grant on any admitted request, release on the last
  // or MAX_PKT-th accepted beat; cutting a packet raises pkt_err.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && admit) begin
          state_d     = LOCK;
          grant_idx_d = winner;
          rr_ptr_d    = winner;
          beat_cnt_d  = '0;
        end
      end
      LOCK: begin
        if (fifo_wrreq) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (end_pkt) begin
            state_d   = IDLE;
            pkt_err_d = at_max & ~req_last[grant_idx_q];
          end
        end
      end
    endcase
  end

  // State register with asynchronous clear of every control flop.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PTR_RST;
      grant_idx_q <= '0;
      beat_cnt_q  <= '0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

endmodule

// File: tb/tb_dcfifo_wr_arbiter.sv
// Directed testbench for dcfifo_wr_arbiter (REQUESTERS=4, WIDTH=8,
// MAX_PKT=16). Source i drives data {i[1:0], seq[5:0]}.
module tb_dcfifo_wr_arbiter;

  localparam int REQUESTERS    = 4;
  localparam int WIDTH         = 8;
  localparam int MAX_PKT       = 16;
  localparam int FIFO_NUMWORDS = 256;
  localparam int FIFO_WIDTHU   = 8;

  logic        clk = 1'b0;
  logic        areset_n = 1'b1;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wrreq;
  logic [7:0]  fifo_data;
  logic        fifo_wrfull;
  logic [7:0]  fifo_wrusedw;
  logic        grant_active;
  logic [1:0]  grant_idx;
  logic        pkt_err;

  always #5 clk = ~clk;

  dcfifo_wr_arbiter #(
    .REQUESTERS    (REQUESTERS),
    .WIDTH         (WIDTH),
    .MAX_PKT       (MAX_PKT),
    .FIFO_NUMWORDS (FIFO_NUMWORDS),
    .FIFO_WIDTHU   (FIFO_WIDTHU)
  ) dut (
    .clk          (clk),
    .areset_n     (areset_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_data    (fifo_data),
    .fifo_wrfull  (fifo_wrfull),
    .fifo_wrusedw (fifo_wrusedw),
    .grant_active (grant_active),
    .grant_idx    (grant_idx),
    .pkt_err      (pkt_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c0;
  int src_rem[4];
  int src_plen[4];
  int src_pos[4];
  int src_seq[4];
  logic [7:0] wr_q[$];
  int wc_q[$];
  int err_q[$];
  int gnt_q[$];
  logic gnt_prev;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int wr_at(input int k);
    return (k < wr_q.size()) ? int'(wr_q[k]) : -1;
  endfunction

  function automatic int wc_at(input int k);
    return (k < wc_q.size()) ? wc_q[k] - c0 : -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (src_rem[i] > 0);
      req_last[i]  = (src_plen[i] != 0) && (src_pos[i] == src_plen[i] - 1);
      req_data[i*8 +: 8] = 8'((i << 6) | (src_seq[i] & 63));
    end
  endtask

  task automatic set_src(input int i, input int total, input int plen);
    src_rem[i]  = total;
    src_plen[i] = plen;
    src_pos[i]  = 0;
    src_seq[i]  = 0;
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wc_q.delete();
    err_q.delete();
    gnt_q.delete();
    gnt_prev = 1'b0;
  endtask

  task automatic start();
    drive();
    #1;
    c0 = cyc;
  endtask

  // Observe one cycle, clock it, then advance any source whose beat was taken.
  task automatic run_cycles(input int n);
    logic [3:0] acc;
    for (int k = 0; k < n; k++) begin
      if (fifo_wrreq) begin
        wr_q.push_back(fifo_data);
        wc_q.push_back(cyc);
      end
      if (pkt_err) err_q.push_back(cyc);
      if (grant_active && !gnt_prev) gnt_q.push_back(int'(grant_idx));
      gnt_prev = grant_active;
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          src_rem[i]--;
          src_seq[i]++;
          if (src_plen[i] != 0 && src_pos[i] == src_plen[i] - 1) src_pos[i] = 0;
          else src_pos[i]++;
        end
      end
      drive();
      #1;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 0, 0);
    drive();
    fifo_wrfull  = 1'b0;
    fifo_wrusedw = 8'd0;
    areset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset_n = 1'b1;
    #1;
    clear_logs();
  endtask

  logic [7:0] exp1[6] = '{8'h00, 8'h01, 8'h02, 8'h80, 8'h81, 8'h82};
  int         cyc1[6] = '{1, 2, 3, 5, 6, 7};
  logic [7:0] exp2[5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01};
  int         gnt2[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < 4; i++) set_src(i, 0, 0);
    drive();
    fifo_wrfull  = 1'b0;
    fifo_wrusedw = 8'd0;
    clear_logs();

    // Reset state, observed while reset is held
    #1 areset_n = 1'b0;
    #3;
    check("rst_grant_active", int'(grant_active), 0);
    check("rst_grant_idx",    int'(grant_idx),    0);
    check("rst_pkt_err",      int'(pkt_err),      0);
    check("rst_req_ready",    int'(req_ready),    0);
    check("rst_fifo_wrreq",   int'(fifo_wrreq),   0);
    check("rst_fifo_data",    int'(fifo_data),    0);
    check("rst_rr_ptr",       int'(dut.rr_ptr_q), 3);
    do_reset();

    // Sources 0 and 2, 3-beat packets each
    set_src(0, 3, 3);
    set_src(2, 3, 3);
    start();
    run_cycles(1);
    check("t1_grant_active", int'(grant_active), 1);
    check("t1_grant_idx",    int'(grant_idx),    0);
    check("t1_req_ready",    int'(req_ready),    1);
    run_cycles(9);
    check("t1_nwrites", wr_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t1_data%0d", k), wr_at(k), int'(exp1[k]));
      check($sformatf("t1_cyc%0d", k),  wc_at(k), cyc1[k]);
    end
    check("t1_rr_ptr", int'(dut.rr_ptr_q), 2);

    // All four sources continuously valid, 1-beat packets
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 100, 1);
    start();
    run_cycles(16);
    check("t2_nwrites", wr_q.size(), 8);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_gnt%0d", k),  (k < gnt_q.size()) ? gnt_q[k] : -1, gnt2[k]);
      check($sformatf("t2_data%0d", k), wr_at(k), int'(exp2[k]));
    end
    check("t2_src0_period", wc_at(4) - wc_at(0), 8);
    check("t2_src1_period", wc_at(5) - wc_at(1), 8);

    // FIFO full for 5 cycles in the middle of a 6-beat packet from source 1
    do_reset();
    set_src(1, 6, 6);
    start();
    run_cycles(3);
    for (int k = 0; k < 5; k++) begin
      fifo_wrfull = 1'b1;
      #1;
      check($sformatf("t3_ready%0d", k), int'(req_ready),    0);
      check($sformatf("t3_wrreq%0d", k), int'(fifo_wrreq),   0);
      check($sformatf("t3_gidx%0d", k),  int'(grant_idx),    1);
      check($sformatf("t3_gact%0d", k),  int'(grant_active), 1);
      run_cycles(1);
    end
    fifo_wrfull = 1'b0;
    #1;
    run_cycles(8);
    check("t3_nwrites", wr_q.size(), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t3_data%0d", k), wr_at(k), 8'h40 + k);
    check("t3_resume_cyc", wc_at(2), 8);
    check("t3_released",   int'(grant_active), 0);

    // Source 1 sends 20 beats with no last: cut at 16
    do_reset();
    set_src(1, 20, 0);
    start();
    run_cycles(25);
    check("t4_nerr",      err_q.size(), 1);
    check("t4_err_cyc",   (err_q.size() > 0) ? err_q[0] - c0 : -1, 17);
    check("t4_nwrites",   wr_q.size(), 20);
    check("t4_beat16",    wr_at(15), 8'h4F);
    check("t4_regrant",   wc_at(16), 18);
    check("t4_beat20",    wr_at(19), 8'h53);
    check("t4_ngrants",   gnt_q.size(), 2);
    check("t4_lock_held", int'(grant_active), 1);

    // Asynchronous reset in the middle of a packet
    do_reset();
    set_src(2, 6, 6);
    start();
    run_cycles(3);
    check("t5_pre_ready", int'(req_ready),  4);
    check("t5_pre_wrreq", int'(fifo_wrreq), 1);
    areset_n = 1'b0;
    #1;
    check("t5_async_ready", int'(req_ready),    0);
    check("t5_async_wrreq", int'(fifo_wrreq),   0);
    check("t5_async_gact",  int'(grant_active), 0);
    for (int i = 0; i < 4; i++) set_src(i, 0, 0);
    drive();
    #3;
    areset_n = 1'b1;
    run_cycles(3);
    check("t5_post_gact",   int'(grant_active), 0);
    check("t5_post_rr_ptr", int'(dut.rr_ptr_q), 3);

`ifdef DCFIFO_WR_ARB_ADMIT_EN
    // Admission: 11 free words is not enough, 16 is
    do_reset();
    fifo_wrusedw = 8'd245;
    set_src(0, 3, 1);
    start();
    run_cycles(4);
    check("t6_blocked_gact", int'(grant_active), 0);
    check("t6_blocked_wr",   wr_q.size(), 0);
    check("t6_blocked_ptr",  int'(dut.rr_ptr_q), 3);
    fifo_wrusedw = 8'd240;
    #1;
    run_cycles(1);
    check("t6_admit_gact", int'(grant_active), 1);
    check("t6_admit_gidx", int'(grant_idx),    0);

    // Full FIFO reports wrusedw=0; still no admission
    do_reset();
    fifo_wrfull  = 1'b1;
    fifo_wrusedw = 8'd0;
    set_src(3, 3, 1);
    start();
    run_cycles(4);
    check("t7_full_gact", int'(grant_active), 0);
    check("t7_full_ptr",  int'(dut.rr_ptr_q), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
